uart_tx_arbiter: RTL and testbench

- Shares one uart_tx instance between NUM_REQ requesters, each of which sends multi-byte messages.
- Grants are round-robin. A grant is held for a whole message, until the byte flagged last.
- Sequences the uart_tx valid/busy handshake, so requesters only see a per-port valid/ready interface.
- Sits between the application clients and uart_tx + uart_baudgen.

---
 rtl/uart_arb_pkg.sv | 17 +
 rtl/uart_rr_pick.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types for the UART TX arbiter: FSM state encoding and
// index-width helper used by the arbiter and the round-robin picker.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker. Searches i_last_idx+1, +2, ...
// modulo NUM_REQ and returns the first request found.
// Ports: i_req (request vector), i_last_idx (previous winner),
//        o_onehot / o_idx (winner), o_any (any request pending).
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_idx,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        w_cand   = i_last_idx;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Step the candidate with explicit wrap so that non power
            // of two NUM_REQ still rotates modulo NUM_REQ.
            w_cand = (w_cand == IDX_W'(NUM_REQ - 1)) ? '0
                                                     : w_cand + IDX_W'(1);
            if (!w_found && i_req[w_cand]) begin
                w_found          = 1'b1;
                o_onehot[w_cand] = 1'b1;
                o_idx            = w_cand;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ message
// senders; a grant is held from the first byte until the byte flagged
// last. Optional macro UART_ARB_TIMEOUT_EN releases an idle grant
// after TIMEOUT_CLKS cycles.
// Ports: i_clk, i_rst (sync, active high); per-requester i_req_valid,
//        i_req_data, i_req_last, o_req_ready; o_grant one-hot owner;
//        o_tx_din / o_tx_valid / i_tx_busy to uart_tx; o_busy.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]            i_req_last,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [DATA_WIDTH-1:0]         o_tx_din,
    output logic                          o_tx_valid,
    input  logic                          i_tx_busy,
    output logic                          o_busy
);

    localparam int IW = idx_w(NUM_REQ);

    state_t                  r_state;
    state_t                  w_next;
    logic [NUM_REQ-1:0]      r_grant;
    logic [IW-1:0]           r_gidx;
    logic [IW-1:0]           r_last_idx;
    logic [DATA_WIDTH-1:0]   r_din;
    logic                    r_tx_valid;
    logic                    r_last_q;

    logic [NUM_REQ-1:0]      w_pick_oh;
    logic [IW-1:0]           w_pick_idx;
    logic                    w_any;
    logic                    w_start;
    logic                    w_hs;
    logic                    w_rel;
    logic                    w_tmo;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_pick (
        .i_req      (i_req_valid),
        .i_last_idx (r_last_idx),
        .o_onehot   (w_pick_oh),
        .o_idx      (w_pick_idx),
        .o_any      (w_any)
    );

    // A new grant also waits for busy low, so a frame left in flight by
    // a reset is never overrun by the next owner.
    assign w_start = (r_state == IDLE) && w_any && !i_tx_busy;
    assign w_hs    = (r_state == SEND) && i_req_valid[r_gidx] && !i_tx_busy;
    assign w_rel   = (r_state == WAIT_DONE) && !i_tx_busy && r_last_q;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    logic [TW-1:0] r_tmo;
    logic          w_idle;

    assign w_idle = (r_state == SEND) && !i_req_valid[r_gidx];

    always_ff @(posedge i_clk) begin
        if (i_rst || !w_idle) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + TW'(1);
        end
    end

    // Fires on the TIMEOUT_CLKS-th consecutive idle SEND cycle.
    assign w_tmo = w_idle && (r_tmo == TW'(TIMEOUT_CLKS - 1));
`else
    logic w_unused_tmo;

    assign w_tmo        = 1'b0;
    assign w_unused_tmo = |TIMEOUT_CLKS;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_start) w_next = SEND;
            end
            SEND: begin
                if (w_tmo)     w_next = IDLE;
                else if (w_hs) w_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (i_tx_busy) w_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!i_tx_busy) w_next = r_last_q ? IDLE : SEND;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grant    <= '0;
            r_gidx     <= '0;
            r_last_idx <= IW'(NUM_REQ - 1);
            r_din      <= '0;
            r_tx_valid <= 1'b0;
            r_last_q   <= 1'b0;
        end else begin
            r_tx_valid <= w_hs;
            if (w_start) begin
                r_grant <= w_pick_oh;
                r_gidx  <= w_pick_idx;
            end
            if (w_hs) begin
                r_din    <= i_req_data[r_gidx*DATA_WIDTH +: DATA_WIDTH];
                r_last_q <= i_req_last[r_gidx];
            end
            if (w_rel || w_tmo) begin
                r_grant    <= '0;
                r_last_idx <= r_gidx;
            end
        end
    end

    always_comb begin
        o_grant     = r_grant;
        o_req_ready = ((r_state == SEND) && !i_tx_busy) ? r_grant : '0;
        o_tx_din    = r_din;
        o_tx_valid  = r_tx_valid;
        o_busy      = (r_state != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural uart_tx
// and per-requester byte queues; output bytes checked via scoreboard.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int FRAME = 12;

    typedef struct {
        logic [N-1:0]   valid;
        logic [N*W-1:0] data;
        int             n_exp;
        logic [31:0]    exp;
    } vec_t;

    logic           clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   i_req_valid;
    logic [N*W-1:0] i_req_data;
    logic [N-1:0]   i_req_last;
    logic [N-1:0]   o_req_ready;
    logic [N-1:0]   o_grant;
    logic [W-1:0]   o_tx_din;
    logic           o_tx_valid;
    logic           tx_busy = 1'b0;
    logic           o_busy;

    int n_vec = 0;
    int n_err = 0;
    int n_txv = 0;
    int ucnt  = 0;

    logic [N-1:0] hs_q = '0;
    logic         prev_txv = 1'b0;
    logic [8:0]   cq [N][$];
    logic [7:0]   sb [$];
    vec_t         tbl [6];

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .DATA_WIDTH   (W),
        .TIMEOUT_CLKS (50)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_grant     (o_grant),
        .o_tx_din    (o_tx_din),
        .o_tx_valid  (o_tx_valid),
        .i_tx_busy   (tx_busy),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < N; k++)
            if (cq[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic post(input int k, input logic [7:0] d, input logic l);
        cq[k].push_back({l, d});
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int t = 0;
        while (!(all_empty() && sb.size() == 0 && !o_busy && !tx_busy)
               && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done"}, 32'(t < budget), 1);
        chk({tag, "_grant0"}, 32'(o_grant), 0);
    endtask

    // uart_tx model: busy rises the cycle after the valid pulse.
    always @(posedge clk) begin
        if (o_tx_valid && !tx_busy) begin
            tx_busy <= 1'b1;
            ucnt    <= FRAME;
        end else if (tx_busy) begin
            if (ucnt == 1) tx_busy <= 1'b0;
            ucnt <= ucnt - 1;
        end
    end

    always @(posedge clk) hs_q <= i_req_valid & o_req_ready;

    // Requester models: present the head of each queue.
    always @(negedge clk) begin
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        logic [N*W-1:0] d;
        logic [8:0]     e;
        v = '0;
        l = '0;
        d = '0;
        for (int k = 0; k < N; k++)
            if (hs_q[k] && cq[k].size() != 0) void'(cq[k].pop_front());
        for (int k = 0; k < N; k++) begin
            if (cq[k].size() != 0) begin
                e          = cq[k][0];
                v[k]       = 1'b1;
                l[k]       = e[8];
                d[k*W +: W] = e[7:0];
            end
        end
        i_req_valid = v;
        i_req_last  = l;
        i_req_data  = d;
    end

    // Scoreboard and structural invariants.
    always @(negedge clk) begin
        if (o_tx_valid) begin
            n_txv++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_tx: got %h expected none", o_tx_din);
            end else begin
                chk("tx_byte", 32'(o_tx_din), 32'(sb.pop_front()));
            end
        end
        if (!i_rst) begin
            if ((o_grant & (o_grant - 1'b1)) != 0) begin
                n_err++;
                $display("FAIL grant_onehot: got %b expected onehot0", o_grant);
            end
            if ((o_req_ready & ~o_grant) != 0) begin
                n_err++;
                $display("FAIL ready_ungranted: got %b expected subset of %b",
                         o_req_ready, o_grant);
            end
            if (o_tx_valid && prev_txv) begin
                n_err++;
                $display("FAIL txv_pulse: got 2-cycle pulse expected 1");
            end
        end
        prev_txv = o_tx_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t;
        int   base;
        bit   bad;
        vec_t v;

        tbl[0] = '{4'b0001, 32'h000000A5, 1, 32'h000000A5};
        tbl[1] = '{4'b1000, 32'h3C000000, 1, 32'h0000003C};
        tbl[2] = '{4'b1111, 32'h43322110, 4, 32'h43322110};
        tbl[3] = '{4'b1111, 32'h43322110, 4, 32'h43322110};
        tbl[4] = '{4'b0110, 32'h00776600, 2, 32'h00007766};
        tbl[5] = '{4'b0101, 32'h00990088, 2, 32'h00009988};

        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(o_grant), 0);
        chk("rst_ready", 32'(o_req_ready), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_txv", 32'(o_tx_valid), 0);
        chk("rst_din", 32'(o_tx_din), 0);
        i_rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            v = tbl[i];
            @(posedge clk);
            for (int k = 0; k < N; k++)
                if (v.valid[k]) post(k, v.data[k*W +: W], 1'b1);
            for (int j = 0; j < v.n_exp; j++)
                sb.push_back(v.exp[j*8 +: 8]);
            wait_idle($sformatf("vec%0d", i), 400);
        end

        // Message lock: req1 three bytes, req2 waits throughout.
        @(posedge clk);
        post(1, 8'h01, 1'b0);
        post(1, 8'h02, 1'b0);
        post(1, 8'h03, 1'b1);
        post(2, 8'hFF, 1'b1);
        sb.push_back(8'h01);
        sb.push_back(8'h02);
        sb.push_back(8'h03);
        sb.push_back(8'hFF);
        bad = 1'b0;
        t = 0;
        while (cq[1].size() != 0 && t < 500) begin
            if (o_req_ready[2]) bad = 1'b1;
            @(negedge clk);
            t++;
        end
        chk("lock_ready2", 32'(bad), 0);
        chk("lock_req2_pending", 32'(cq[2].size()), 1);
        wait_idle("lock", 400);

        // Idle grant: req0 leaves a message open while req3 waits.
        @(posedge clk);
        post(0, 8'h55, 1'b0);
        sb.push_back(8'h55);
        t = 0;
        while (cq[0].size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        post(3, 8'h77, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
        t = 0;
        while (o_grant != 4'b1000 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("tmo_grant3", 32'(o_grant), 32'h8);
        sb.push_back(8'h77);
        @(posedge clk);
        post(0, 8'h56, 1'b1);
        sb.push_back(8'h56);
`else
        bad = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (o_grant != 4'b0001 || o_req_ready[3]) bad = 1'b1;
        end
        chk("hold_grant0", 32'(bad), 0);
        chk("hold_req3_pending", 32'(cq[3].size()), 1);
        @(posedge clk);
        post(0, 8'h56, 1'b1);
        sb.push_back(8'h56);
        sb.push_back(8'h77);
`endif
        wait_idle("hold", 400);

        // Reset during WAIT_DONE of byte 2 of 3.
        @(posedge clk);
        base = n_txv;
        post(1, 8'hAA, 1'b0);
        post(1, 8'hBB, 1'b0);
        post(1, 8'hCC, 1'b1);
        sb.push_back(8'hAA);
        sb.push_back(8'hBB);
        t = 0;
        while ((n_txv < base + 2 || !tx_busy) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("rstmid_reach", 32'(t < 500), 1);
        @(negedge clk);
        @(posedge clk);
        cq[1].delete();
        post(2, 8'hDD, 1'b1);
        sb.push_back(8'hDD);
        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        chk("rstmid_grant", 32'(o_grant), 0);
        chk("rstmid_busy", 32'(o_busy), 0);
        chk("rstmid_inflight", 32'(tx_busy), 1);
        bad = 1'b0;
        t = 0;
        while (tx_busy && t < 100) begin
            if (o_grant != 0) bad = 1'b1;
            @(negedge clk);
            t++;
        end
        chk("rstmid_wait_busy", 32'(bad), 0);
        wait_idle("rstmid", 400);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
